read_channel_dispatcher: RTL and testbench

- Read-side counterpart of the write arbiter. Accepts read requests from num_of_ports channels and picks one per cycle by round-robin. Issues the winner's address to the SRAM read port.
- Tracks the owning port of each in-flight read through the fixed SRAM read latency. Returns the read data to the owning port with a one-hot valid.
- Sits between the per-port read interfaces and the SRAM macro, in parallel with the write arbiter.

---
 rtl/read_channel_dispatcher.sv | 98 +++++++++
 tb/tb_read_channel_dispatcher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/read_channel_dispatcher.sv
// Round-robin read dispatcher: arbitrates per-port read requests onto one SRAM read port
// and routes each returning word back to its requester through a tag pipeline.
module read_channel_dispatcher #(
    parameter int num_of_ports       = 16,
    parameter int arbiter_data_width = 256,
    parameter int addr_width         = 14,
    parameter int sram_latency       = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [num_of_ports-1:0]              rd_req,
    input  logic [num_of_ports*addr_width-1:0]   rd_addr,
    output logic [num_of_ports-1:0]              rd_grant,
    output logic                                 sram_rd_en,
    output logic [addr_width-1:0]                sram_rd_addr,
    input  logic [arbiter_data_width-1:0]        sram_rd_data,
    output logic [arbiter_data_width-1:0]        rd_data_out,
    output logic [num_of_ports-1:0]              rd_valid
);

    localparam int IDX_W = (num_of_ports > 1) ? $clog2(num_of_ports) : 1;

    logic [num_of_ports-1:0]       r_grant;
    logic                          r_sram_en;
    logic [addr_width-1:0]         r_sram_addr;
    logic [IDX_W-1:0]              r_ptr;
    logic [arbiter_data_width-1:0] r_data_out;
    logic [num_of_ports-1:0]       r_valid;

    // Stage 0 coincides with the read strobe; stage sram_latency lines up with sram_rd_data.
    logic [sram_latency:0]         r_tag_vld;
    logic [IDX_W-1:0]              r_tag_idx [0:sram_latency];

    logic [num_of_ports-1:0]       w_eligible;
    logic                          w_found;
    logic [IDX_W-1:0]              w_winner;
    logic [IDX_W-1:0]              w_ptr_next;

    always_comb begin
        int idx;
        w_eligible = rd_req & ~r_grant;
        w_found    = 1'b0;
        w_winner   = '0;
        idx        = 0;
        for (int i = 0; i < num_of_ports; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= num_of_ports) begin
                idx = idx - num_of_ports;
            end
            if (!w_found && w_eligible[idx]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(idx);
            end
        end
        w_ptr_next = (w_winner == IDX_W'(num_of_ports - 1)) ? '0 : w_winner + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_sram_en   <= 1'b0;
            r_sram_addr <= '0;
            r_ptr       <= '0;
            r_data_out  <= '0;
            r_valid     <= '0;
            r_tag_vld   <= '0;
            for (int s = 0; s <= sram_latency; s++) begin
                r_tag_idx[s] <= '0;
            end
        end else begin
            r_sram_en <= w_found;
            r_grant   <= w_found ? (num_of_ports'(1) << w_winner) : '0;
            if (w_found) begin
                r_sram_addr <= rd_addr[w_winner*addr_width +: addr_width];
                r_ptr       <= w_ptr_next;
            end

            r_tag_vld[0] <= w_found;
            r_tag_idx[0] <= w_winner;
            for (int s = 1; s <= sram_latency; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end

            r_valid <= r_tag_vld[sram_latency] ? (num_of_ports'(1) << r_tag_idx[sram_latency]) : '0;
            if (r_tag_vld[sram_latency]) begin
                r_data_out <= sram_rd_data;
            end
        end
    end

    assign rd_grant     = r_grant;
    assign sram_rd_en   = r_sram_en;
    assign sram_rd_addr = r_sram_addr;
    assign rd_data_out  = r_data_out;
    assign rd_valid     = r_valid;

endmodule

// File: tb/tb_read_channel_dispatcher.sv
// Bench for read_channel_dispatcher: SRAM latency model, behavioural arbitration/return model
// compared every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_read_channel_dispatcher;

    localparam int N   = 16;
    localparam int DW  = 256;
    localparam int AW  = 14;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      rd_req;
    logic [N*AW-1:0]   rd_addr;
    logic [N-1:0]      rd_grant;
    logic              sram_rd_en;
    logic [AW-1:0]     sram_rd_addr;
    logic [DW-1:0]     sram_rd_data = '0;
    logic [DW-1:0]     rd_data_out;
    logic [N-1:0]      rd_valid;

    int checks = 0;
    int errors = 0;
    bit auto_drop = 1'b1;

    read_channel_dispatcher #(
        .num_of_ports(N), .arbiter_data_width(DW), .addr_width(AW), .sram_latency(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_grant(rd_grant), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .rd_data_out(rd_data_out), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
        if (a == 14'h0123) return {32{8'hA5}};
        return DW'(a);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM: data for a strobe in cycle C is presented during cycle C+LAT; otherwise junk.
    logic [LAT:0]  h_en = '0;
    logic [AW-1:0] h_addr [0:LAT];
    always @(posedge clk) begin
        #1;
        for (int i = LAT; i > 0; i--) begin
            h_en[i]   = h_en[i-1];
            h_addr[i] = h_addr[i-1];
        end
        h_en[0]   = sram_rd_en;
        h_addr[0] = sram_rd_addr;
        sram_rd_data = h_en[LAT] ? sram_word(h_addr[LAT]) : {8{32'hDEADBEEF}};
    end

    typedef struct packed {
        int           due;
        logic [N-1:0] port;
        logic [DW-1:0] data;
    } ret_t;
    ret_t exp_q[$];

    logic [N-1:0]  m_grant = '0;
    logic          m_en    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [N-1:0]  m_valid = '0;
    logic [DW-1:0] m_data  = '0;
    int            m_ptr   = 0;
    int            cyc     = 0;

    always @(negedge clk) begin
        logic [N-1:0] elig;
        int win;
        cyc++;
        if (!rst_n) begin
            m_grant = '0; m_en = 1'b0; m_addr = '0; m_valid = '0; m_data = '0; m_ptr = 0;
            exp_q.delete();
        end
        chk("model rd_grant", DW'(rd_grant), DW'(m_grant));
        chk("model sram_rd_en", DW'(sram_rd_en), DW'(m_en));
        chk("model sram_rd_addr", DW'(sram_rd_addr), DW'(m_addr));
        chk("model rd_valid", DW'(rd_valid), DW'(m_valid));
        chk("model rd_data_out", rd_data_out, m_data);
        if (rst_n) begin
            elig = rd_req & ~m_grant;
            win  = -1;
            for (int i = 0; i < N; i++) begin
                int p;
                p = (m_ptr + i) % N;
                if (win < 0 && elig[p]) win = p;
            end
            if (win >= 0) begin
                m_grant = N'(1) << win;
                m_en    = 1'b1;
                m_addr  = rd_addr[win*AW +: AW];
                m_ptr   = (win + 1) % N;
                exp_q.push_back('{due: cyc + 2 + LAT, port: N'(1) << win, data: sram_word(m_addr)});
            end else begin
                m_grant = '0;
                m_en    = 1'b0;
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc + 1) begin
                m_valid = exp_q[0].port;
                m_data  = exp_q[0].data;
                void'(exp_q.pop_front());
            end else begin
                m_valid = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) rd_req = rd_req & ~rd_grant;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        logic [N-1:0] seen;
        rst_n = 1'b0; rd_req = '0; rd_addr = '0;
        repeat (3) tick();
        #1;
        chk("reset rd_grant", DW'(rd_grant), '0);
        chk("reset sram_rd_en", DW'(sram_rd_en), '0);
        chk("reset rd_valid", DW'(rd_valid), '0);
        chk("reset rd_data_out", rd_data_out, '0);
        rst_n = 1'b1;
        repeat (10) tick();
        #1;
        chk("idle sram_rd_en", DW'(sram_rd_en), '0);
        chk("idle rd_valid", DW'(rd_valid), '0);

        // Single read on port 5
        set_addr(5, 14'h0123);
        rd_req[5] = 1'b1;
        tick(); #1;
        chk("single rd_grant", DW'(rd_grant), DW'(16'h0020));
        chk("single sram_rd_addr", DW'(sram_rd_addr), DW'(14'h0123));
        chk("single sram_rd_en", DW'(sram_rd_en), DW'(1'b1));
        repeat (3) tick();
        #1;
        chk("single rd_valid", DW'(rd_valid), DW'(16'h0020));
        chk("single rd_data_out", rd_data_out, {32{8'hA5}});
        repeat (2) tick();

        // Fairness: all ports requesting from pointer 0
        do_reset();
        for (int k = 0; k < N; k++) set_addr(k, AW'(14'h0100 + k));
        rd_req = '1;
        for (int i = 0; i < N; i++) begin
            tick(); #1;
            chk($sformatf("rr grant %0d", i), DW'(rd_grant), DW'(N'(1) << i));
        end
        repeat (5) tick();
        rd_req = N'((1 << 3) | (1 << 12));
        tick(); #1;
        chk("rr re-request first", DW'(rd_grant), DW'(16'h0008));
        tick(); #1;
        chk("rr re-request second", DW'(rd_grant), DW'(16'h1000));

        // Wrap-around from pointer 14
        tick();
        rd_req[13] = 1'b1;
        repeat (2) tick();
        rd_req = N'((1 << 2) | (1 << 15));
        tick(); #1;
        chk("wrap first", DW'(rd_grant), DW'(16'h8000));
        tick(); #1;
        chk("wrap second", DW'(rd_grant), DW'(16'h0004));
        tick();
        rd_req = N'((1 << 2) | (1 << 3));
        tick(); #1;
        chk("wrap pointer at 3", DW'(rd_grant), DW'(16'h0008));
        repeat (6) tick();

        // Back-to-back return routing, pointer moved to 1 first
        rd_req[0] = 1'b1;
        repeat (2) tick();
        set_addr(1, 14'h0111); set_addr(7, 14'h0777); set_addr(9, 14'h0999);
        rd_req = N'((1 << 1) | (1 << 7) | (1 << 9));
        tick(); #1; chk("b2b grant 1", DW'(rd_grant), DW'(16'h0002));
        tick(); #1; chk("b2b grant 7", DW'(rd_grant), DW'(16'h0080));
        tick(); #1; chk("b2b grant 9", DW'(rd_grant), DW'(16'h0200));
        tick(); #1;
        chk("b2b valid 1", DW'(rd_valid), DW'(16'h0002));
        chk("b2b data 1", rd_data_out, DW'(14'h0111));
        tick(); #1;
        chk("b2b valid 7", DW'(rd_valid), DW'(16'h0080));
        chk("b2b data 7", rd_data_out, DW'(14'h0777));
        tick(); #1;
        chk("b2b valid 9", DW'(rd_valid), DW'(16'h0200));
        chk("b2b data 9", rd_data_out, DW'(14'h0999));
        repeat (3) tick();

        // Continuous request from one port: granted every second cycle
        auto_drop = 1'b0;
        rd_req = N'(1 << 6);
        cnt = 0;
        repeat (6) begin
            tick(); #1;
            if (rd_grant[6]) cnt++;
        end
        chk("hold grant count", DW'(cnt), DW'(3));
        rd_req = '0;
        auto_drop = 1'b1;
        repeat (6) tick();

        // Reset while a read to port 4 is in flight
        set_addr(4, 14'h0444);
        rd_req[4] = 1'b1;
        tick(); #1;
        chk("flight grant 4", DW'(rd_grant), DW'(16'h0010));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = '0;
        repeat (8) begin
            tick(); #1;
            seen = seen | rd_valid;
        end
        chk("flight no rd_valid", DW'(seen), '0);
        rd_req = N'((1 << 2) | (1 << 5));
        tick(); #1;
        chk("flight pointer restart", DW'(rd_grant), DW'(16'h0004));
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
